// File: rtl/life_engine_ctrl_pkg.sv
// life_engine_ctrl_pkg: FSM state encoding and elaboration-time sizing/index helpers
// shared by the Game of Life engine files.
package life_engine_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction
endpackage

// File: rtl/life_engine_ctrl_if.sv
// life_engine_ctrl_if: control pulses, row editing and board/status outputs of the Life engine.
interface life_engine_ctrl_if
    import life_engine_ctrl_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
);
    localparam int RW = clog2(ROWS);
    logic                 run_toggle;
    logic                 step_i;
    logic                 clear_i;
    logic                 row_up;
    logic                 row_down;
    logic                 row_load;
    logic [COLS-1:0]      row_data;
    logic [ROWS*COLS-1:0] board_o;
    logic [GEN_W-1:0]     generation_cnt_o;
    logic [1:0]           state_o;
    logic [RW-1:0]        row_sel_o;
    logic                 stable_o;
    logic                 extinct_o;
    modport master (
        output run_toggle, step_i, clear_i, row_up, row_down, row_load, row_data,
        input  board_o, generation_cnt_o, state_o, row_sel_o, stable_o, extinct_o
    );
    modport slave (
        input  run_toggle, step_i, clear_i, row_up, row_down, row_load, row_data,
        output board_o, generation_cnt_o, state_o, row_sel_o, stable_o, extinct_o
    );
endinterface

// File: rtl/life_engine_ctrl_next_gen.sv
// life_next_gen: combinational B3/S23 next-board generator with toroidal or dead-edge
// neighbourhoods, plus next==current and next==0 flags.
module life_next_gen
    import life_engine_ctrl_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int WRAP = 1
) (
    input  logic [ROWS*COLS-1:0] board_i,
    output logic [ROWS*COLS-1:0] next_o,
    output logic                 same_o,
    output logic                 zero_o
);
    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            logic [8:0] nb;
            logic [3:0] cnt;
            for (genvar k = 0; k < 9; k++) begin : g_k
                localparam int NR = r + k / 3 - 1;
                localparam int NC = c + k % 3 - 1;
                localparam bit INSIDE = NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS;
                localparam int IDX = cell_idx((NR + ROWS) % ROWS, (NC + COLS) % COLS, COLS);
                // k==4 is the cell itself; without wrap, off-board neighbours read as dead
                assign nb[k] = (k != 4 && (WRAP != 0 || INSIDE)) ? board_i[IDX] : 1'b0;
            end
            assign cnt = 4'($countones(nb));
            assign next_o[cell_idx(r, c, COLS)] = cnt == 4'd3 || (board_i[cell_idx(r, c, COLS)] && cnt == 4'd2);
        end
    end
    assign same_o = next_o == board_i;
    assign zero_o = next_o == '0;
endmodule

// File: rtl/life_engine_ctrl.sv
// life_engine_ctrl: single-clock Game of Life engine with row editing, tick-driven run,
// single stepping, saturating generation count and still-life/extinction halt.
module life_engine_ctrl
    import life_engine_ctrl_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int TICK_W    = 28,
    parameter int GEN_W     = 16,
    parameter int WRAP      = 1,
    parameter int AUTO_HALT = 1
) (
    input logic               ClkPort,
    input logic               reset,
    life_engine_ctrl_if.slave bus
);
    localparam int RW = clog2(ROWS);
    localparam int N  = ROWS * COLS;
    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q;
    logic [N-1:0]      board_q, board_d, next_b;
    logic [GEN_W-1:0]  gen_q;
    logic [RW-1:0]     sel_q, sel_d;
    logic              stable_q, same, zero, tick, editable, load_ok, adv, clr;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP)) u_next (
        .board_i(board_q),
        .next_o (next_b),
        .same_o (same),
        .zero_o (zero)
    );

    // tick marks the terminal count, i.e. the edge on which the counter wraps to 0
    assign tick     = &tick_q;
    assign editable = state_q == ST_SET || state_q == ST_PAUSE;
    assign load_ok  = bus.row_load && editable;
    assign adv      = !load_ok && ((state_q == ST_RUN && tick) || (bus.step_i && editable));
    assign clr      = reset || bus.clear_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SET:   state_d = bus.run_toggle ? ST_RUN : ST_SET;
            ST_RUN:   state_d = bus.run_toggle ? ST_PAUSE :
                                (tick && AUTO_HALT != 0 && (same || zero)) ? ST_HALT : ST_RUN;
            ST_PAUSE: state_d = bus.run_toggle ? ST_RUN : ST_PAUSE;
            default:  state_d = bus.run_toggle ? ST_PAUSE : ST_HALT;
        endcase
        if (clr) state_d = ST_SET;
    end

    assign sel_d = clr ? '0 :
                   (bus.row_up && !bus.row_down) ? (sel_q == RW'(ROWS - 1) ? '0 : sel_q + 1'b1) :
                   (bus.row_down && !bus.row_up) ? (sel_q == '0 ? RW'(ROWS - 1) : sel_q - 1'b1) :
                   sel_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign board_d[r*COLS +: COLS] = clr ? '0 :
                                         (load_ok && sel_q == RW'(r)) ? bus.row_data :
                                         adv ? next_b[r*COLS +: COLS] : board_q[r*COLS +: COLS];
    end

    always_ff @(posedge ClkPort) begin
        state_q  <= state_d;
        board_q  <= board_d;
        sel_q    <= sel_d;
        tick_q   <= reset ? '0 : tick_q + 1'b1;
        gen_q    <= clr ? '0 : (adv && !(&gen_q)) ? gen_q + 1'b1 : gen_q;
        stable_q <= (clr || load_ok) ? 1'b0 : adv ? same : stable_q;
    end

    assign bus.board_o          = board_q;
    assign bus.generation_cnt_o = gen_q;
    assign bus.state_o          = state_q;
    assign bus.row_sel_o        = sel_q;
    assign bus.stable_o         = stable_q;
    assign bus.extinct_o        = board_q == '0;
endmodule
